// File: rtl/button_event_if.sv
// Event bundle between a debounced button source and the button_event decoder.
// "release" is a language keyword, so the falling-edge pulse is named rel.
interface button_event_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in;
    logic             press;
    logic             rel;
    logic             short_press;
    logic             long_press;
    logic             double_press;
    logic             held;
    logic [CNT_W-1:0] count;

    modport master (
        output in,
        input  press, rel, short_press, long_press, double_press, held, count
    );

    modport slave (
        input  in,
        output press, rel, short_press, long_press, double_press, held, count
    );
endinterface

// File: rtl/button_event.sv
// Turns a clean button level into one-cycle press/release/short/long/double pulses
// and a wrapping press counter. Every output is registered.
module button_event #(
    parameter int unsigned LONG_CYCLES = 8,
    parameter int unsigned DBL_GAP     = 6,
    parameter int unsigned CNT_W       = 8
) (
    input logic           clk,
    input logic           rst,
    button_event_if.slave bus
);

    localparam int unsigned TMR_MAX = (LONG_CYCLES > DBL_GAP) ? LONG_CYCLES : DBL_GAP;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(DBL_GAP - 1);

    typedef enum logic [2:0] {StIdle, StDown, StLong, StGap, StDown2} state_e;

    state_e           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             in_q;
    logic             armed_q;
    logic             press_q;
    logic             rel_q;
    logic             short_q;
    logic             long_q;
    logic             dbl_q;
    logic [CNT_W-1:0] count_q;

    logic rise;
    logic fall;

    assign rise = bus.in & ~in_q;
    assign fall = ~bus.in & in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Loading in_q from the live input hides a button held through reset.
            in_q    <= bus.in;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            count_q <= '0;
            tmr_q   <= '0;
            state_q <= StIdle;
        end else begin
            in_q    <= bus.in;
            press_q <= rise;
            // A press that began before reset never reports its release.
            rel_q   <= fall & armed_q;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            if (rise) begin
                armed_q <= 1'b1;
                count_q <= count_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_q <= StDown;
                        tmr_q   <= TMR_W'(1);
                    end
                end
                StDown: begin
                    if (bus.in) begin
                        if (tmr_q == LONG_LAST) begin
                            long_q  <= 1'b1;
                            state_q <= StLong;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end else begin
                        state_q <= StGap;
                        tmr_q   <= '0;
                    end
                end
                StLong: begin
                    if (!bus.in) begin
                        state_q <= StIdle;
                    end
                end
                StGap: begin
                    // A rise on the expiry edge still counts as a double press.
                    if (bus.in) begin
                        dbl_q   <= 1'b1;
                        state_q <= StDown2;
                    end else if (tmr_q == GAP_LAST) begin
                        short_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StDown2: begin
                    if (!bus.in) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.press        = press_q;
    assign bus.rel          = rel_q;
    assign bus.short_press  = short_q;
    assign bus.long_press   = long_q;
    assign bus.double_press = dbl_q;
    assign bus.held         = in_q;
    assign bus.count        = count_q;

endmodule
